// File: rtl/mouse_shot_ctl.sv
// Debounced single-shot trigger with cooldown, ammo tracking and
// press-time cursor capture, running in the 65 MHz mouse clock domain.
// Every output is a register. shot_valid_out is a one-cycle pulse, with no
// back-pressure. shot_xpos_out/shot_ypos_out hold the cursor position from
// the start of the press that produced the shot, and are valid while the pulse is high.
module mouse_shot_ctl #(
    parameter int DEBOUNCE_CYCLES = 65_000,
    parameter int COOLDOWN_CYCLES = 6_500_000,
    parameter int AMMO_MAX        = 3,
    parameter int AW              = $clog2(AMMO_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [11:0]   xpos_in,
    input  logic [11:0]   ypos_in,
    input  logic          mouse_left_in,
    input  logic          reload_in,
    output logic          shot_valid_out,
    output logic [11:0]   shot_xpos_out,
    output logic [11:0]   shot_ypos_out,
    output logic [AW-1:0] ammo_out,
    output logic          empty_out,
    output logic          busy_out
);

    // One counter serves both timed states, so it is sized for the longer of the two.
    localparam int MAXC = (DEBOUNCE_CYCLES > COOLDOWN_CYCLES) ? DEBOUNCE_CYCLES : COOLDOWN_CYCLES;
    localparam int CW   = $clog2(MAXC) + 1;

    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] COOL_LAST = CW'(COOLDOWN_CYCLES - 1);
    localparam logic [AW-1:0] AMMO_FULL = AW'(AMMO_MAX);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        PRESS        = 3'd1,
        FIRE         = 3'd2,
        COOLDOWN     = 3'd3,
        WAIT_RELEASE = 3'd4
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [AW-1:0] ammo_next;
    logic          capture;
    logic          fire;

    // Next-state, counter and ammo logic. The counter is cleared whenever a state is entered.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        capture    = 1'b0;
        fire       = 1'b0;
        case (state)
            IDLE: begin
                if (mouse_left_in) begin
                    cnt_next = '0;
                    if (ammo_out != '0) begin
                        state_next = PRESS;
                        capture    = 1'b1;
                    end else begin
                        state_next = WAIT_RELEASE;
                    end
                end
            end
            PRESS: begin
                if (!mouse_left_in) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_next = FIRE;
                    fire       = 1'b1;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            FIRE: begin
                state_next = COOLDOWN;
                cnt_next   = '0;
            end
            COOLDOWN: begin
                if (cnt == COOL_LAST) begin
                    state_next = WAIT_RELEASE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            WAIT_RELEASE: begin
                if (!mouse_left_in) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase

        // A reload takes priority over the decrement for the shot being fired.
        // The decrement is guarded so the count can never wrap below zero.
        if (reload_in) begin
            ammo_next = AMMO_FULL;
        end else if (fire && (ammo_out != '0)) begin
            ammo_next = ammo_out - 1'b1;
        end else begin
            ammo_next = ammo_out;
        end
    end

    // State register, counter, and registered outputs.
    // The pulse and the ammo decrement appear in the same cycle as the FIRE state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            shot_valid_out <= 1'b0;
            shot_xpos_out  <= '0;
            shot_ypos_out  <= '0;
            ammo_out       <= AMMO_FULL;
            empty_out      <= 1'b0;
            busy_out       <= 1'b0;
        end else begin
            state          <= state_next;
            cnt            <= cnt_next;
            shot_valid_out <= fire;
            ammo_out       <= ammo_next;
            empty_out      <= (ammo_next == '0);
            busy_out       <= (state_next != IDLE);
            if (capture) begin
                shot_xpos_out <= xpos_in;
                shot_ypos_out <= ypos_in;
            end
        end
    end

endmodule

// File: tb/tb_mouse_shot_ctl.sv
// Directed bench for mouse_shot_ctl with DEBOUNCE_CYCLES=4, COOLDOWN_CYCLES=10 and AMMO_MAX=3.
// Inputs change 1 ns after a rising edge. Outputs are checked after that same edge.
module tb_mouse_shot_ctl;

    localparam int D  = 4;
    localparam int C  = 10;
    localparam int A  = 3;
    localparam int AW = $clog2(A + 1);

    logic          clk;
    logic          rst;
    logic [11:0]   xpos_in;
    logic [11:0]   ypos_in;
    logic          mouse_left_in;
    logic          reload_in;
    logic          shot_valid_out;
    logic [11:0]   shot_xpos_out;
    logic [11:0]   shot_ypos_out;
    logic [AW-1:0] ammo_out;
    logic          empty_out;
    logic          busy_out;

    int checks   = 0;
    int failures = 0;
    int pulses;

    mouse_shot_ctl #(
        .DEBOUNCE_CYCLES(D),
        .COOLDOWN_CYCLES(C),
        .AMMO_MAX(A)
    ) dut (
        .clk(clk),
        .rst(rst),
        .xpos_in(xpos_in),
        .ypos_in(ypos_in),
        .mouse_left_in(mouse_left_in),
        .reload_in(reload_in),
        .shot_valid_out(shot_valid_out),
        .shot_xpos_out(shot_xpos_out),
        .shot_ypos_out(shot_ypos_out),
        .ammo_out(ammo_out),
        .empty_out(empty_out),
        .busy_out(busy_out)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Run n cycles with the button held at lvl, and count the shot pulses.
    task automatic hold(input int n, input logic lvl, output int npulse);
        npulse        = 0;
        mouse_left_in = lvl;
        for (int i = 0; i < n; i++) begin
            step();
            if (shot_valid_out === 1'b1) npulse++;
        end
    endtask

    initial begin
        rst = 1'b1; xpos_in = '0; ypos_in = '0; mouse_left_in = 1'b0; reload_in = 1'b0;

        // 1. reset values
        step(); step();
        rst = 1'b0;
        step();
        chk("rst_valid", 32'(shot_valid_out), 0);
        chk("rst_x",     32'(shot_xpos_out), 0);
        chk("rst_y",     32'(shot_ypos_out), 0);
        chk("rst_ammo",  32'(ammo_out), 3);
        chk("rst_empty", 32'(empty_out), 0);
        chk("rst_busy",  32'(busy_out), 0);

        // 2. basic shot latency, and the latched position while the cursor moves
        xpos_in = 12'd100; ypos_in = 12'd200; mouse_left_in = 1'b1;
        step();
        chk("t2_busy", 32'(busy_out), 1);
        chk("t2_x_cap", 32'(shot_xpos_out), 100);
        xpos_in = 12'd300; ypos_in = 12'd400;
        for (int i = 2; i <= 4; i++) begin
            step();
            chk($sformatf("t2_nopulse_%0d", i), 32'(shot_valid_out), 0);
        end
        step();
        chk("t2_pulse", 32'(shot_valid_out), 1);
        chk("t2_x",     32'(shot_xpos_out), 100);
        chk("t2_y",     32'(shot_ypos_out), 200);
        chk("t2_ammo",  32'(ammo_out), 2);
        step();
        chk("t2_pulse_off", 32'(shot_valid_out), 0);
        chk("t2_cooldown_busy", 32'(busy_out), 1);
        hold(C + 3, 1'b0, pulses);
        chk("t2_extra_pulses", 32'(pulses), 0);
        chk("t2_idle", 32'(busy_out), 0);

        // 3. a glitch shorter than the debounce time is rejected
        reload_in = 1'b1; step(); reload_in = 1'b0;
        chk("t3_reload", 32'(ammo_out), 3);
        xpos_in = 12'd10; ypos_in = 12'd20;
        hold(3, 1'b1, pulses);
        xpos_in = 12'd55;
        chk("t3_press_busy", 32'(busy_out), 1);
        hold(1, 1'b0, pulses);
        chk("t3_pulses", 32'(pulses), 0);
        chk("t3_idle", 32'(busy_out), 0);
        chk("t3_ammo", 32'(ammo_out), 3);
        chk("t3_x_kept", 32'(shot_xpos_out), 10);
        chk("t3_y_kept", 32'(shot_ypos_out), 20);

        // 4. a long hold fires exactly once; release and press again fires a second shot
        hold(60, 1'b1, pulses);
        chk("t4_one_pulse", 32'(pulses), 1);
        chk("t4_ammo1", 32'(ammo_out), 2);
        chk("t4_wait_busy", 32'(busy_out), 1);
        hold(1, 1'b0, pulses);
        chk("t4_released", 32'(busy_out), 0);
        hold(20, 1'b1, pulses);
        chk("t4_second_pulse", 32'(pulses), 1);
        chk("t4_ammo2", 32'(ammo_out), 1);
        hold(1, 1'b0, pulses);

        // 5. the last shot empties the magazine; a further press does nothing
        xpos_in = 12'd7; ypos_in = 12'd8;
        hold(20, 1'b1, pulses);
        chk("t5_third_pulse", 32'(pulses), 1);
        chk("t5_ammo0", 32'(ammo_out), 0);
        chk("t5_empty", 32'(empty_out), 1);
        hold(1, 1'b0, pulses);
        xpos_in = 12'd999;
        hold(20, 1'b1, pulses);
        chk("t5_no_pulse", 32'(pulses), 0);
        chk("t5_ammo_nowrap", 32'(ammo_out), 0);
        chk("t5_no_capture", 32'(shot_xpos_out), 7);
        chk("t5_wait_busy", 32'(busy_out), 1);
        hold(1, 1'b0, pulses);
        chk("t5_idle", 32'(busy_out), 0);
        reload_in = 1'b1; step(); reload_in = 1'b0;
        chk("t5_reload_ammo", 32'(ammo_out), 3);
        chk("t5_reload_empty", 32'(empty_out), 0);

        // 6a. a reload on the same edge as the fire decrement wins, and so does one during FIRE
        hold(4, 1'b1, pulses);
        chk("t6_prefire", 32'(pulses), 0);
        reload_in = 1'b1;
        step();
        chk("t6_pulse", 32'(shot_valid_out), 1);
        chk("t6_reload_wins", 32'(ammo_out), 3);
        step();
        reload_in = 1'b0;
        chk("t6_reload_fire", 32'(ammo_out), 3);
        hold(C + 3, 1'b0, pulses);
        chk("t6_idle", 32'(busy_out), 0);

        // 6b. a reset in the middle of PRESS cancels the pending shot
        xpos_in = 12'd42;
        hold(2, 1'b1, pulses);
        chk("t6_press", 32'(busy_out), 1);
        rst = 1'b1;
        #1;
        chk("t6_async_busy", 32'(busy_out), 0);
        chk("t6_async_x", 32'(shot_xpos_out), 0);
        mouse_left_in = 1'b0;
        step();
        rst = 1'b0;
        hold(10, 1'b0, pulses);
        chk("t6_rst_no_pulse", 32'(pulses), 0);
        chk("t6_rst_idle", 32'(busy_out), 0);
        chk("t6_rst_ammo", 32'(ammo_out), 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog: if the run stalls, report it and stop.
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
